// File: rtl/seq_mult_if.sv
// ============================================================================
// Module   : seq_mult_if
// Purpose  : start/busy/done handshake bundle for seq_mult. Optional sgn
//            member when SEQ_MULT_SIGNED_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_mult_if #(
  parameter int WIDTH = 4
);
  logic                   start;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     p;
`ifdef SEQ_MULT_SIGNED_EN
  logic                   sgn;

  modport master (output start, a, b, sgn, input  busy, done, p);
  modport slave  (input  start, a, b, sgn, output busy, done, p);
`else
  modport master (output start, a, b, input  busy, done, p);
  modport slave  (input  start, a, b, output busy, done, p);
`endif
endinterface

`default_nettype wire

// File: rtl/seq_mult.sv
// ============================================================================
// Module   : seq_mult
// Purpose  : Iterative shift-add multiplier, one partial product per clock,
//            WIDTH x WIDTH -> 2*WIDTH. SEQ_MULT_SIGNED_EN adds two's
//            complement operands selected by sgn.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_mult #(
  parameter int WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  seq_mult_if.slave   bus
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     p_q, p_d;

  logic              accept;
  logic [WIDTH-1:0]  mag_a;
  logic [WIDTH-1:0]  mag_b;
  logic [PW-1:0]     addend;
  logic [PW-1:0]     acc_sum;
  logic [PW-1:0]     result;

`ifdef SEQ_MULT_SIGNED_EN
  logic              neg_q, neg_d;
  logic              neg_a;
  logic              neg_b;

  // The magnitude of -2^(WIDTH-1) still fits WIDTH unsigned bits.
  assign neg_a  = bus.sgn & bus.a[WIDTH-1];
  assign neg_b  = bus.sgn & bus.b[WIDTH-1];
  assign mag_a  = neg_a ? (~bus.a + 1'b1) : bus.a;
  assign mag_b  = neg_b ? (~bus.b + 1'b1) : bus.b;
  assign result = neg_q ? (~acc_sum + 1'b1) : acc_sum;
`else
  assign mag_a  = bus.a;
  assign mag_b  = bus.b;
  assign result = acc_sum;
`endif

  assign accept  = bus.start && (state_q != S_RUN);
  assign addend  = mplier_q[0] ? mcand_q : '0;
  assign acc_sum = acc_q + addend;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    p_d      = p_q;
`ifdef SEQ_MULT_SIGNED_EN
    neg_d    = neg_q;
`endif

    case (state_q)
      S_RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          p_d     = result;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // IDLE and DONE both accept a new operation, so DONE can chain with no bubble.
    if (accept) begin
      mcand_d  = {{WIDTH{1'b0}}, mag_a};
      mplier_d = mag_b;
      acc_d    = '0;
      cnt_d    = '0;
      state_d  = S_RUN;
`ifdef SEQ_MULT_SIGNED_EN
      neg_d    = neg_a ^ neg_b;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      p_q      <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      p_q      <= p_d;
`ifdef SEQ_MULT_SIGNED_EN
      neg_q    <= neg_d;
`endif
    end
  end

  assign bus.busy = (state_q == S_RUN);
  assign bus.done = (state_q == S_DONE);
  assign bus.p    = p_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_mult.sv
// ============================================================================
// Module   : tb_seq_mult
// Purpose  : Scoreboard bench for seq_mult (WIDTH=4): directed operands,
//            expected product and done cycle queued at issue time.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_mult;

  localparam int W  = 4;
  localparam int PW = 2 * W;

  typedef struct {
    logic [PW-1:0] p;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  seq_mult_if #(.WIDTH(W)) bus ();

  seq_mult #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a negedge; the next posedge accepts, done shows W cycles later.
  task automatic issue(input logic [W-1:0] ai, input logic [W-1:0] bi,
                       input logic s, input logic [PW-1:0] exp_p);
    bus.a     = ai;
    bus.b     = bi;
`ifdef SEQ_MULT_SIGNED_EN
    bus.sgn   = s;
`else
    if (s) $display("note: signed operands requested in unsigned build");
`endif
    bus.start = 1'b1;
    sb.push_back('{exp_p, cyc + 1 + W});
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    chk("busy_done_excl", {63'd0, bus.busy & bus.done}, 64'd0);
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 p=%0h expected no pending result (cycle %0d)", bus.p, cyc);
      end else begin
        e = sb.pop_front();
        chk("product", {{(64-PW){1'b0}}, bus.p}, {{(64-PW){1'b0}}, e.p});
        chk("latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
`ifdef SEQ_MULT_SIGNED_EN
    bus.sgn   = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_busy", {63'd0, bus.busy}, 64'd0);
    chk("reset_done", {63'd0, bus.done}, 64'd0);
    chk("reset_p", {{(64-PW){1'b0}}, bus.p}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Maximum operands, busy for exactly W cycles, then p holds.
    issue(4'd15, 4'd15, 1'b0, 8'hE1);
    for (int i = 0; i < W; i++) begin
      chk("busy_run", {63'd0, bus.busy}, 64'd1);
      @(negedge clk);
    end
    chk("busy_in_done", {63'd0, bus.busy}, 64'd0);
    @(negedge clk);
    chk("done_single", {63'd0, bus.done}, 64'd0);
    chk("p_hold", {{(64-PW){1'b0}}, bus.p}, 64'hE1);
    repeat (2) @(negedge clk);

    // Zero operands and identity.
    issue(4'd0, 4'd9, 1'b0, 8'd0);
    repeat (W + 2) @(negedge clk);
    issue(4'd9, 4'd0, 1'b0, 8'd0);
    repeat (W + 2) @(negedge clk);
    issue(4'd1, 4'd13, 1'b0, 8'd13);
    repeat (W + 2) @(negedge clk);

    // Starts during busy are ignored.
    issue(4'd6, 4'd7, 1'b0, 8'd42);
    bus.a     = 4'd2;
    bus.b     = 4'd2;
    bus.start = 1'b1;
    repeat (3) @(negedge clk);
    bus.start = 1'b0;
    repeat (W + 3) @(negedge clk);

    // Start held high: back-to-back results every W+1 cycles.
    bus.a     = 4'd3;
    bus.b     = 4'd5;
    bus.start = 1'b1;
    k = cyc;
    for (int i = 0; i < 3; i++) sb.push_back('{8'd15, k + 1 + W + i * (W + 1)});
    repeat (2 * (W + 1) + 1) @(negedge clk);
    bus.start = 1'b0;
    repeat (W + 3) @(negedge clk);

    // Reset in the second RUN cycle aborts; a start on the reset edge is ignored.
    issue(4'd12, 4'd11, 1'b0, 8'd132);
    @(negedge clk);
    rst       = 1'b1;
    bus.a     = 4'd2;
    bus.b     = 4'd3;
    bus.start = 1'b1;
    @(negedge clk);
    sb.delete();
    rst       = 1'b0;
    bus.start = 1'b0;
    chk("abort_busy", {63'd0, bus.busy}, 64'd0);
    chk("abort_done", {63'd0, bus.done}, 64'd0);
    chk("abort_p", {{(64-PW){1'b0}}, bus.p}, 64'd0);
    @(negedge clk);
    chk("abort_start_ignored", {63'd0, bus.busy}, 64'd0);
    repeat (W + 2) @(negedge clk);
    issue(4'd2, 4'd3, 1'b0, 8'd6);
    repeat (W + 2) @(negedge clk);

`ifdef SEQ_MULT_SIGNED_EN
    issue(4'h8, 4'h7, 1'b1, 8'hC8);
    repeat (W + 2) @(negedge clk);
    issue(4'h8, 4'h8, 1'b1, 8'h40);
    repeat (W + 2) @(negedge clk);
    issue(4'h8, 4'h7, 1'b0, 8'h38);
    repeat (W + 2) @(negedge clk);
`endif

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_mult.md
Name: seq_mult

Overview:
- Parametrised, iterative shift-add multiplier. Successor to the fixed 4-bit combinational array multiplier.
- Trades one partial-product row per clock for area. Supports any operand width.
- Adds a start/busy/done handshake so a controlling FSM or datapath can issue multiplies back-to-back.
- Sits beside the combinational multiplier. Used wherever a multi-cycle latency is acceptable.

Parameters:
- WIDTH, 4, operand width in bits (>=2). Product width is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when the block is idle or done
- a  input  WIDTH  multiplicand; captured on an accepted start
- b  input  WIDTH  multiplier; captured on an accepted start
- busy  output  1  high while iterating
- done  output  1  single-cycle pulse; p is valid for the new result
- p  output  2*WIDTH  product; holds its value until the next done

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: busy=0, done=0, p=0. Internal state goes to IDLE, counter=0, accumulator=0.
- FSM states: IDLE, RUN, DONE.
- IDLE: on start=1, capture a and b into internal registers. Clear the accumulator, set counter=0, go to RUN. On start=0, stay.
- RUN, once per cycle:
  - If the current multiplier LSB is 1, add the multiplicand (shifted left by counter) into the 2*WIDTH accumulator. Otherwise add zero.
  - Shift the multiplier register right by one. Increment counter.
  - After WIDTH RUN cycles, i.e. on the edge where counter==WIDTH-1, load p from the final accumulator value and go to DONE.
- DONE: done=1 for exactly this one cycle.
  - start=1: accept immediately, same as IDLE (back-to-back issue, no bubble).
  - start=0: go to IDLE.
- busy=1 exactly while in RUN. done and busy are never high together.
- Latency: start sampled at edge N gives RUN in cycles N+1..N+WIDTH. done=1 and p valid in the cycle after edge N+WIDTH. Total: WIDTH+1 cycles from the start edge to the done cycle.
- Throughput: one result per WIDTH+1 cycles.
- start while busy=1 is ignored. Operands and result are unaffected. No queuing.
- a and b may change freely after the accepting edge; only the captured copies are used.
- Arithmetic: unsigned, exact. The accumulator is 2*WIDTH bits wide, so overflow is impossible. Maximum result is (2^WIDTH-1)^2.
- rst during RUN or DONE:
  - Abort next cycle: busy=0, done=0, p=0.
  - No done pulse for the aborted operation.
  - A start on the same edge as rst is ignored.
- p changes only on the DONE transition or on reset.

Optional Feature:
- Macro: SEQ_MULT_SIGNED_EN
- Defined: adds input port sgn (1 bit), sampled with start.
  - sgn=1: a and b are two's complement. Capture their magnitudes and record sign = a[MSB]^b[MSB].
  - Iterate on the magnitudes. On the transition into DONE, p = sign ? -magnitude_product : magnitude_product, 2*WIDTH-bit two's complement.
  - The most-negative operands are handled exactly: -2^(WIDTH-1) has a WIDTH-bit unsigned magnitude.
  - sgn=0: identical to the unsigned behaviour.
  - Latency unchanged.
- Undefined: the sgn port does not exist. Unsigned only.

Test Plan:
- WIDTH=4, rst then start with a=15, b=15 -> busy for 4 cycles, done pulse 5 cycles after the start edge, p=225 (8'hE1). p holds 225 after done drops.
- a=0, b=9, then a=9, b=0 -> p=0 both times. a=1, b=13 -> p=13. Same latency every time.
- start with a=6, b=7, then start pulses with a=2, b=2 during busy -> ignored. p=42. Exactly one done.
- start held high continuously with a=3, b=5 -> done every 5 cycles, p=15, no bubble between results.
- start a=12, b=11, then assert rst in the 2nd RUN cycle -> next cycle busy=0, done=0, p=0, no done pulse. A new start a=2, b=3 yields p=6 normally.
- SEQ_MULT_SIGNED_EN defined, WIDTH=4, sgn=1:
  - a=-8 (4'h8), b=7 -> p=-56 (8'hC8).
  - a=-8, b=-8 -> p=64 (8'h40).
  - sgn=0, a=4'h8, b=4'h7 -> p=56 (8'h38).
